// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR read checker and the write-side pattern source.
package ddr_test_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/ddr_pat_gen.sv
// Byte pattern source: load a seed, then step per strobe as incrementing or LFSR.
module ddr_pat_gen
  import ddr_test_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] pat
);
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] pat_q, pat_d;

  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    if (load) begin
      mode_d = mode;
      // An all-zero LFSR state would lock up, so it is swapped for all-ones.
      pat_d  = (mode == MODE_LFSR && seed == '0) ? {DATA_W{1'b1}} : seed;
    end else if (adv) begin
      pat_d = (mode_q == MODE_LFSR) ? lfsr_next(pat_q) : pat_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_INC;
      pat_q  <= '0;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
    end
  end

  assign pat = pat_q;
endmodule

// File: rtl/ddr_rd_checker.sv
// Read-data checker: compares a burst of read bytes against a generated pattern.
module ddr_rd_checker
  import ddr_test_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              chk_start,
  input  logic              chk_mode,
  input  logic [DATA_W-1:0] chk_seed,
  input  logic [LEN_W-1:0]  chk_len,
  input  logic              rd_valid_in,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              chk_busy,
  output logic              chk_done,
  output logic              chk_pass,
  output logic              tg_compare_error,
  output logic [15:0]       err_cnt,
  output logic [LEN_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic              timeout
);
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d, fidx_q, fidx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       err_q, err_d;
  logic [DATA_W-1:0] fdata_q, fdata_d, exp_pat;
  logic              tg_q, tg_d, to_q, to_d, pass_q, pass_d;
  logic              done_q, done_d, busy_q, busy_d;
  logic              start_ok, in_run, beat, mism, last, idle_cyc, to_hit, enter_done;

  assign start_ok = (state_q == ST_IDLE) && chk_start && init_calib_complete;
  assign in_run   = (state_q == ST_RUN) && (len_q != '0);
  assign beat     = in_run && rd_valid_in;
  assign mism     = beat && (rd_data_in != exp_pat);
  assign last     = beat && (idx_q == len_q - LEN_W'(1));
  assign idle_cyc = in_run && !rd_valid_in;
  assign to_hit   = idle_cyc && (gap_q == GAP_W'(TIMEOUT_CYC - 1));

  ddr_pat_gen #(.DATA_W(DATA_W)) u_pat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .adv   (beat),
    .mode  (chk_mode),
    .seed  (chk_seed),
    .pat   (exp_pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if ((len_q == '0) || last || to_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_done = (state_q == ST_RUN) && (state_d == ST_DONE);

  always_comb begin
    len_d   = len_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    err_d   = err_q;
    tg_d    = tg_q;
    to_d    = to_q;
    fidx_d  = fidx_q;
    fdata_d = fdata_q;
    pass_d  = pass_q;
    if (start_ok) begin
      len_d   = chk_len;
      idx_d   = '0;
      gap_d   = '0;
      err_d   = '0;
      tg_d    = 1'b0;
      to_d    = 1'b0;
      fidx_d  = '0;
      fdata_d = '0;
      pass_d  = 1'b0;
    end
    if (beat) begin
      idx_d = idx_q + LEN_W'(1);
      gap_d = '0;
    end
    if (mism) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      tg_d = 1'b1;
      if (!tg_q) begin
        fidx_d  = idx_q;
        fdata_d = rd_data_in;
      end
    end
    if (idle_cyc) gap_d = gap_q + GAP_W'(1);
    if (to_hit)   to_d  = 1'b1;
    // Result folds in the final beat's compare, which lands in the same edge.
    if (enter_done) pass_d = (err_d == '0) && !to_d;
  end

  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = enter_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      err_q   <= '0;
      tg_q    <= 1'b0;
      to_q    <= 1'b0;
      fidx_q  <= '0;
      fdata_q <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      len_q   <= len_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      tg_q    <= tg_d;
      to_q    <= to_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign chk_busy         = busy_q;
  assign chk_done         = done_q;
  assign chk_pass         = pass_q;
  assign tg_compare_error = tg_q;
  assign err_cnt          = err_q;
  assign first_err_idx    = fidx_q;
  assign first_err_data   = fdata_q;
  assign timeout          = to_q;
endmodule

// File: tb/tb_ddr_rd_checker.sv
// Directed bench for ddr_rd_checker with a short beat-gap timeout.
module tb_ddr_rd_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_calib_complete = 1'b0;
  logic        chk_start = 1'b0;
  logic        chk_mode = 1'b0;
  logic [7:0]  chk_seed = '0;
  logic [15:0] chk_len = '0;
  logic        rd_valid_in = 1'b0;
  logic [7:0]  rd_data_in = '0;
  logic        chk_busy, chk_done, chk_pass, tg_compare_error, timeout;
  logic [15:0] err_cnt, first_err_idx;
  logic [7:0]  first_err_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_wait;

  ddr_rd_checker #(.DATA_W(8), .LEN_W(16), .TIMEOUT_CYC(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .chk_start           (chk_start),
    .chk_mode            (chk_mode),
    .chk_seed            (chk_seed),
    .chk_len             (chk_len),
    .rd_valid_in         (rd_valid_in),
    .rd_data_in          (rd_data_in),
    .chk_busy            (chk_busy),
    .chk_done            (chk_done),
    .chk_pass            (chk_pass),
    .tg_compare_error    (tg_compare_error),
    .err_cnt             (err_cnt),
    .first_err_idx       (first_err_idx),
    .first_err_data      (first_err_data),
    .timeout             (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic m, input logic [7:0] s, input logic [15:0] l);
    chk_start = 1'b1; chk_mode = m; chk_seed = s; chk_len = l;
    tick();
    chk_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    rd_valid_in = 1'b1; rd_data_in = d;
    tick();
    rd_valid_in = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, chk_busy}, 0);
    chk({tag, "_done"}, {31'd0, chk_done}, 0);
    chk({tag, "_pass"}, {31'd0, chk_pass}, 0);
    chk({tag, "_tg"},   {31'd0, tg_compare_error}, 0);
    chk({tag, "_err"},  {16'd0, err_cnt}, 0);
    chk({tag, "_fidx"}, {16'd0, first_err_idx}, 0);
    chk({tag, "_fdat"}, {24'd0, first_err_data}, 0);
    chk({tag, "_to"},   {31'd0, timeout}, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    tick(); tick();
    rst_n = 1'b1;
    init_calib_complete = 1'b1;
    tick();

    // Incrementing with 0xFF wrap; a junk beat in the start cycle must be ignored.
    rd_valid_in = 1'b1; rd_data_in = 8'h55;
    start(1'b0, 8'hFE, 16'd4);
    rd_valid_in = 1'b0;
    chk("t1_busy", {31'd0, chk_busy}, 1);
    beat(8'hFE); beat(8'hFF); beat(8'h00);
    chk("t1_nodone", {31'd0, chk_done}, 0);
    rd_valid_in = 1'b1; rd_data_in = 8'h01;
    tick();
    rd_data_in = 8'h77;  // beyond len, lands in DONE
    chk("t1_done", {31'd0, chk_done}, 1);
    chk("t1_pass", {31'd0, chk_pass}, 1);
    chk("t1_err",  {16'd0, err_cnt}, 0);
    chk("t1_busy0", {31'd0, chk_busy}, 0);
    tick();
    rd_valid_in = 1'b0;
    chk("t1_done1", {31'd0, chk_done}, 0);
    chk("t1_err_after", {16'd0, err_cnt}, 0);
    chk("t1_pass_hold", {31'd0, chk_pass}, 1);
    tick();

    // Two mismatches at beats 5 and 6.
    start(1'b0, 8'h10, 16'd8);
    beat(8'h10); beat(8'h11); beat(8'h12); beat(8'h13); beat(8'h14);
    chk("t2_err_pre", {16'd0, err_cnt}, 0);
    beat(8'hAA);
    chk("t2_err1", {16'd0, err_cnt}, 1);
    chk("t2_tg1", {31'd0, tg_compare_error}, 1);
    beat(8'h00);
    beat(8'h17);
    chk("t2_done", {31'd0, chk_done}, 1);
    chk("t2_err",  {16'd0, err_cnt}, 2);
    chk("t2_fidx", {16'd0, first_err_idx}, 5);
    chk("t2_fdat", {24'd0, first_err_data}, 32'hAA);
    chk("t2_tg",   {31'd0, tg_compare_error}, 1);
    chk("t2_pass", {31'd0, chk_pass}, 0);
    tick(); tick();

    // LFSR, zero seed replaced by 0xFF.
    start(1'b1, 8'h00, 16'd3);
    chk("t3_clr", {16'd0, err_cnt}, 0);
    beat(8'hFF); beat(8'hFE); beat(8'hFC);
    chk("t3_done", {31'd0, chk_done}, 1);
    chk("t3_pass", {31'd0, chk_pass}, 1);
    chk("t3_tg",   {31'd0, tg_compare_error}, 0);
    tick(); tick();

    // Beat-gap timeout after 4 of 10 beats.
    start(1'b0, 8'h00, 16'd10);
    beat(8'h00); beat(8'h01); beat(8'h02); beat(8'h03);
    n_wait = 0;
    for (int i = 0; i < 40 && !chk_done; i++) begin
      tick();
      n_wait++;
    end
    chk("t4_done", {31'd0, chk_done}, 1);
    chk("t4_gap",  n_wait, 16);
    chk("t4_to",   {31'd0, timeout}, 1);
    chk("t4_pass", {31'd0, chk_pass}, 0);
    chk("t4_err",  {16'd0, err_cnt}, 0);
    tick(); tick();

    // Restart while RUN must be ignored.
    start(1'b0, 8'h00, 16'd2);
    chk("t5_to_clr", {31'd0, timeout}, 0);
    rd_valid_in = 1'b1; rd_data_in = 8'h00;
    chk_start = 1'b1; chk_seed = 8'h80; chk_len = 16'd5;
    tick();
    chk_start = 1'b0;
    rd_data_in = 8'h01;
    tick();
    rd_valid_in = 1'b0;
    chk("t5_done", {31'd0, chk_done}, 1);
    chk("t5_pass", {31'd0, chk_pass}, 1);
    tick(); tick();

    // Start without calibration is ignored.
    init_calib_complete = 1'b0;
    start(1'b0, 8'h00, 16'd3);
    chk("t6_nocal", {31'd0, chk_busy}, 0);
    tick();
    chk("t6_nocal_done", {31'd0, chk_done}, 0);
    init_calib_complete = 1'b1;

    // Zero-length check completes on the first RUN cycle.
    start(1'b0, 8'h00, 16'd0);
    chk("t7_busy", {31'd0, chk_busy}, 1);
    tick();
    chk("t7_done", {31'd0, chk_done}, 1);
    chk("t7_pass", {31'd0, chk_pass}, 1);
    tick(); tick();

    // Reset mid-RUN clears everything at once and suppresses done.
    start(1'b0, 8'h00, 16'd5);
    beat(8'h00); beat(8'h99);
    chk("t8_err_pre", {16'd0, err_cnt}, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t8_rst");
    tick(); tick(); tick();
    chk("t8_nodone", {31'd0, chk_done}, 0);
    rst_n = 1'b1;
    tick();
    start(1'b0, 8'h20, 16'd2);
    beat(8'h20); beat(8'h21);
    chk("t8_done", {31'd0, chk_done}, 1);
    chk("t8_pass", {31'd0, chk_pass}, 1);
    chk("t8_err",  {16'd0, err_cnt}, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
